// File: rtl/mac_sequencer_if.sv
// Bundles the job request, operand stream, processor drive and result port of mac_sequencer.
// The sequencer uses the slave view; its environment (job source, processor, sink) uses master.
interface mac_sequencer_if #(
  parameter int DW = 8,
  parameter int RW = 20,
  parameter int LW = 4
);
  logic          start_i;
  logic [LW-1:0] len_i;
  logic          busy_o;
  logic          in_valid_i;
  logic [DW-1:0] in_a_i;
  logic [DW-1:0] in_b_i;
  logic          in_ready_o;
  logic [DW-1:0] a_o;
  logic [DW-1:0] b_o;
  logic          enable_o;
  logic          retro_o;
  logic          done_i;
  logic [RW-1:0] proc_out_i;
  logic          res_valid_o;
  logic [RW-1:0] res_o;
  logic          res_ready_i;

  modport slave (
    input  start_i, len_i, in_valid_i, in_a_i, in_b_i, done_i, proc_out_i, res_ready_i,
    output busy_o, in_ready_o, a_o, b_o, enable_o, retro_o, res_valid_o, res_o
  );

  modport master (
    output start_i, len_i, in_valid_i, in_a_i, in_b_i, done_i, proc_out_i, res_ready_i,
    input  busy_o, in_ready_o, a_o, b_o, enable_o, retro_o, res_valid_o, res_o
  );
endinterface

// File: rtl/mac_sequencer.sv
// Operand sequencer for the MAC processor: streams len operand pairs into it, counts its done
// pulses, and holds the final accumulated output on a valid/ready result port.
module mac_sequencer #(
  parameter int DW    = 8,
  parameter int RW    = 20,
  parameter int N_MAX = 8,
  parameter int LW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  mac_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] acc_cnt_q, acc_cnt_d;
  logic [LW-1:0] done_cnt_q, done_cnt_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          enable_q, enable_d;
  logic          retro_q, retro_d;
  logic [RW-1:0] res_q, res_d;
  logic          res_valid_q, res_valid_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic          len_ok;
  logic [LW-1:0] acc_next;
  logic [LW-1:0] done_next;

  assign accept    = (state_q == S_FEED) && bus.in_valid_i;
  assign len_ok    = (bus.len_i != '0) && (bus.len_i <= LW'(N_MAX));
  assign acc_next  = acc_cnt_q + LW'(1);
  assign done_next = done_cnt_q + LW'(1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave it unassigned (no latch).
    state_d     = state_q;
    len_d       = len_q;
    acc_cnt_d   = acc_cnt_q;
    done_cnt_d  = done_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    enable_d    = 1'b0;
    retro_d     = retro_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i && len_ok) begin
          len_d      = bus.len_i;
          acc_cnt_d  = '0;
          done_cnt_d = '0;
          state_d    = S_FEED;
        end
      end
      S_FEED: begin
        if (accept) begin
          a_d       = bus.in_a_i;
          b_d       = bus.in_b_i;
          enable_d  = 1'b1;
          // First term overwrites the processor accumulator, later terms add to it.
          retro_d   = (acc_cnt_q != '0);
          acc_cnt_d = acc_next;
          if (acc_next == len_q) state_d = S_WAIT;
        end
      end
      S_WAIT: ;
      S_HOLD: begin
        if (bus.res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The processor reports one done per product; only the len-th carries the full sum.
    if (((state_q == S_FEED) || (state_q == S_WAIT)) && bus.done_i) begin
      done_cnt_d = done_next;
      if (done_next == len_q) begin
        res_d       = bus.proc_out_i;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      done_cnt_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      enable_q    <= 1'b0;
      retro_q     <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      len_q       <= len_d;
      acc_cnt_q   <= acc_cnt_d;
      done_cnt_q  <= done_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      enable_q    <= enable_d;
      retro_q     <= retro_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready_o  = (state_q == S_FEED);
  assign bus.busy_o      = busy_q;
  assign bus.a_o         = a_q;
  assign bus.b_o         = b_q;
  assign bus.enable_o    = enable_q;
  assign bus.retro_o     = retro_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_o       = res_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural MAC processor and a result scoreboard.
module tb_mac_sequencer;
  localparam int DW    = 8;
  localparam int RW    = 20;
  localparam int N_MAX = 8;
  localparam int LW    = 4;

  logic clk;
  logic rst;

  mac_sequencer_if #(.DW(DW), .RW(RW), .LW(LW)) bus ();

  mac_sequencer #(.DW(DW), .RW(RW), .N_MAX(N_MAX), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Processor model: product registered the cycle enable is seen, done one cycle later.
  logic          p_done;
  logic [RW-1:0] p_acc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_done <= 1'b0;
      p_acc  <= '0;
    end else begin
      p_done <= bus.enable_o;
      if (bus.enable_o)
        p_acc <= (bus.retro_o ? p_acc : '0) + RW'(bus.a_o) * RW'(bus.b_o);
    end
  end
  assign bus.done_i     = p_done;
  assign bus.proc_out_i = p_acc;

  int n_pass  = 0;
  int n_total = 0;
  longint exp_q[$];

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard monitor: compares each result handshake against the oldest expected value.
  always @(negedge clk) begin
    if (rst && bus.res_valid_o && bus.res_ready_i) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_result", longint'(bus.res_o), 0);
      end else begin
        longint e;
        e = exp_q.pop_front();
        check(longint'(bus.res_o) == e, "res_o", longint'(bus.res_o), e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job. gap: idle cycles between pairs; hold: cycles res_ready is held low with a
  // start pulse during HOLD; abort_after > 0: reset after that many pairs are accepted.
  task automatic run_job(input int n, input int av[8], input int bv[8], input int gap,
                         input longint expv, input int hold, input int abort_after);
    bus.res_ready_i = (hold == 0);
    bus.start_i = 1'b1;
    bus.len_i   = LW'(n);
    exp_q.push_back(expv);
    tick();
    bus.start_i = 1'b0;
    check(bus.busy_o == 1'b1, "busy_after_start", bus.busy_o, 1);
    for (int i = 0; i < n; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_a_i     = DW'(av[i]);
      bus.in_b_i     = DW'(bv[i]);
      @(negedge clk);
      check(bus.in_ready_o == 1'b1, "in_ready_feed", bus.in_ready_o, 1);
      tick();
      check(bus.enable_o == 1'b1, "enable_pulse", bus.enable_o, 1);
      check(bus.retro_o == (i != 0), "retro", bus.retro_o, (i != 0));
      bus.in_valid_i = 1'b0;
      if (abort_after > 0 && i + 1 == abort_after) begin
        rst = 1'b0;
        #1;
        check({bus.busy_o, bus.in_ready_o, bus.enable_o, bus.retro_o, bus.res_valid_o} == 5'b0,
              "reset_ctrl_outputs", {bus.busy_o, bus.in_ready_o, bus.enable_o, bus.retro_o, bus.res_valid_o}, 0);
        check(bus.a_o == '0 && bus.b_o == '0 && bus.res_o == '0, "reset_data_outputs",
              longint'(bus.a_o) + longint'(bus.b_o) + longint'(bus.res_o), 0);
        void'(exp_q.pop_back());
        tick();
        rst = 1'b1;
        tick();
        return;
      end
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check(bus.enable_o == 1'b0, "enable_gap", bus.enable_o, 0);
        end
      end
    end
    tick();
    check(bus.res_valid_o == 1'b0, "res_valid_at_L2", bus.res_valid_o, 0);
    tick();
    check(bus.res_valid_o == 1'b1, "res_valid_at_L3", bus.res_valid_o, 1);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        bus.start_i = (h == 1);
        bus.len_i   = LW'(2);
        check(bus.res_valid_o == 1'b1 && bus.res_o == RW'(expv), "hold_stable",
              longint'(bus.res_o), expv);
        tick();
      end
      bus.start_i     = 1'b0;
      bus.res_ready_i = 1'b1;
      tick();
      check(bus.busy_o == 1'b0, "idle_after_ready", bus.busy_o, 0);
      check(bus.res_valid_o == 1'b0, "valid_cleared", bus.res_valid_o, 0);
      tick();
      check(bus.in_ready_o == 1'b0, "hold_start_ignored", bus.in_ready_o, 0);
    end else begin
      tick();
      check(bus.busy_o == 1'b0, "idle_at_n_plus_4", bus.busy_o, 0);
    end
    begin
      int t = 0;
      while (bus.busy_o && t < 100) begin
        tick();
        t++;
      end
      check(bus.busy_o == 1'b0, "job_complete_timeout", bus.busy_o, 0);
    end
  endtask

  task automatic invalid_start(input int len);
    bus.start_i = 1'b1;
    bus.len_i   = LW'(len);
    tick();
    bus.start_i = 1'b0;
    check(bus.busy_o == 1'b0, "invalid_len_busy", bus.busy_o, 0);
    check(bus.in_ready_o == 1'b0, "invalid_len_ready", bus.in_ready_o, 0);
    tick();
    check(bus.busy_o == 1'b0, "invalid_len_busy2", bus.busy_o, 0);
  endtask

  initial begin
    int a3[8], b3[8], amax[8], bmax[8], a9[8], b9[8], a4[8], b4[8], ar[8], br[8];
    a3   = '{2, 4, 1, 0, 0, 0, 0, 0};
    b3   = '{3, 5, 7, 0, 0, 0, 0, 0};
    amax = '{255, 255, 255, 255, 255, 255, 255, 255};
    bmax = '{255, 255, 255, 255, 255, 255, 255, 255};
    a9   = '{9, 0, 0, 0, 0, 0, 0, 0};
    b9   = '{9, 0, 0, 0, 0, 0, 0, 0};
    a4   = '{5, 6, 7, 8, 0, 0, 0, 0};
    b4   = '{1, 2, 3, 4, 0, 0, 0, 0};
    ar   = '{3, 1, 0, 0, 0, 0, 0, 0};
    br   = '{3, 1, 0, 0, 0, 0, 0, 0};

    rst            = 1'b0;
    bus.start_i    = 1'b0;
    bus.len_i      = '0;
    bus.in_valid_i = 1'b0;
    bus.in_a_i     = '0;
    bus.in_b_i     = '0;
    bus.res_ready_i = 1'b1;
    #1;
    tick();
    check({bus.busy_o, bus.in_ready_o, bus.enable_o, bus.retro_o, bus.res_valid_o} == 5'b0,
          "reset_state", {bus.busy_o, bus.in_ready_o, bus.enable_o, bus.retro_o, bus.res_valid_o}, 0);
    check(bus.res_o == '0, "reset_res", longint'(bus.res_o), 0);
    rst = 1'b1;
    tick();

    run_job(3, a3, b3, 0, 33, 0, 0);          // basic
    run_job(3, a3, b3, 2, 33, 0, 0);          // operand bubbles
    run_job(8, amax, bmax, 0, 520200, 0, 0);  // maximum values
    run_job(1, a9, b9, 0, 81, 5, 0);          // result backpressure
    invalid_start(0);
    invalid_start(9);
    run_job(4, a4, b4, 0, 0, 0, 2);           // reset mid-job
    run_job(2, ar, br, 0, 10, 0, 0);          // recovery job

    repeat (3) tick();
    check(exp_q.size() == 0, "results_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
